// File: rtl/imm_decode_pipe_pkg.sv
// Shared definitions for the immediate-decode pipeline.
// Contents:
//   OPC_*        7-bit major opcodes recognised by the decoder
//   fmt_e        3-bit immediate format code reported alongside each immediate
//   shamt_width  width of the shift-amount field (5 for RV32, 6 for RV64)
package imm_decode_pipe_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R     = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_INV   = 3'd7
    } fmt_e;

    function automatic int shamt_width(input bit rv64);
        return rv64 ? 6 : 5;
    endfunction

endpackage

// File: rtl/imm_decode_pipe_decode.sv
// imm_decode: purely combinational immediate generator.
// Turns one 32-bit instruction word into its sign-correct immediate,
// format code and an illegal flag. Shared with the compressed-expander path.
// Ports:
//   i_inst     32    raw instruction word
//   o_imm      XLEN  decoded immediate (sign- or zero-extended as the format demands)
//   o_fmt      3     format code (fmt_e)
//   o_illegal  1     opcode not supported by this configuration
module imm_decode #(
    parameter int XLEN  = 32,
    parameter int RV64I = 0
) (
    input  logic [31:0]     i_inst,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_fmt,
    output logic            o_illegal
);
    import imm_decode_pipe_pkg::*;

    localparam int          SW         = shamt_width(RV64I != 0);
    localparam logic [31:0] SHAMT_MASK = (32'd1 << SW) - 32'd1;

    logic [6:0]         w_opcode;
    logic [2:0]         w_funct3;
    logic               w_is_shift;
    fmt_e               w_fmt;
    logic signed [31:0] w_imm32;

    assign w_opcode   = i_inst[6:0];
    assign w_funct3   = i_inst[14:12];
    assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

    // Every supported opcode ends in 2'b11, so a word with inst[1:0] != 2'b11
    // never matches a case item and falls through to FMT_INV.
    always_comb begin
        w_fmt = FMT_INV;
        case (w_opcode)
            OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: w_fmt = FMT_I;
            OPC_OP_IMM:    w_fmt = w_is_shift ? FMT_SHAMT : FMT_I;
            OPC_OP_IMM_32: if (RV64I != 0) w_fmt = w_is_shift ? FMT_SHAMT : FMT_I;
            OPC_STORE:     w_fmt = FMT_S;
            OPC_BRANCH:    w_fmt = FMT_B;
            OPC_LUI, OPC_AUIPC: w_fmt = FMT_U;
            OPC_JAL:       w_fmt = FMT_J;
            OPC_OP:        w_fmt = FMT_R;
            OPC_OP_32:     if (RV64I != 0) w_fmt = FMT_R;
            default:       w_fmt = FMT_INV;
        endcase
    end

    // Immediates are assembled at 32 bits and sign-extended once to XLEN.
    // The shift amount is zero-extended; masking drops inst[30] and any
    // bits above the configured shamt width.
    always_comb begin
        w_imm32 = '0;
        case (w_fmt)
            FMT_I:     w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            FMT_SHAMT: w_imm32 = (i_inst >> 20) & SHAMT_MASK;
            FMT_S:     w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            FMT_B:     w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                                  i_inst[30:25], i_inst[11:8], 1'b0};
            FMT_U:     w_imm32 = {i_inst[31:12], 12'b0};
            FMT_J:     w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                                  i_inst[20], i_inst[30:21], 1'b0};
            default:   w_imm32 = '0;
        endcase
    end

    assign o_imm     = XLEN'(w_imm32);
    assign o_fmt     = w_fmt;
    assign o_illegal = (w_fmt == FMT_INV);

endmodule

// File: rtl/imm_decode_pipe.sv
// imm_decode_pipe: decode-stage immediate generator with a DEPTH-entry
// in-order output queue. The immediate, format, illegal flag and pc+imm
// are computed at enqueue and stored; the head entry is presented on out_*.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   drop all queued entries and the same-cycle input
//   in_valid/in_ready       input handshake (in_ready from registered count only)
//   in_inst, in_pc          instruction word and its PC
//   out_valid/out_ready     output handshake for the head entry
//   out_imm, out_fmt        head immediate and format code
//   out_target              out_pc + out_imm modulo 2^XLEN
//   out_illegal             head instruction unsupported
module imm_decode_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int RV64I = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);
    import imm_decode_pipe_pkg::*;

    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [XLEN-1:0] r_imm     [DEPTH];
    logic [2:0]      r_fmt     [DEPTH];
    logic            r_illegal [DEPTH];
    logic [XLEN-1:0] r_target  [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_fmt;
    logic            w_illegal;
    logic [XLEN-1:0] w_target;
    logic            w_push;
    logic            w_pop;

    imm_decode #(.XLEN(XLEN), .RV64I(RV64I)) u_decode (
        .i_inst    (in_inst),
        .o_imm     (w_imm),
        .o_fmt     (w_fmt),
        .o_illegal (w_illegal)
    );

    // Carry out of the top bit is intentionally dropped.
    assign w_target = in_pc + w_imm;

    // in_ready depends only on the count register, so a full queue refuses a
    // push even if the head is popped in the same cycle.
    assign in_ready  = (r_count != FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready;

    // Pointers and count. Flush overrides any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_imm[r_wr_ptr]     <= w_imm;
            r_fmt[r_wr_ptr]     <= w_fmt;
            r_illegal[r_wr_ptr] <= w_illegal;
            r_target[r_wr_ptr]  <= w_target;
        end
    end

    // Data outputs are forced to zero while empty so stale entries never leak.
    assign out_imm     = out_valid ? r_imm[r_rd_ptr]     : '0;
    assign out_fmt     = out_valid ? r_fmt[r_rd_ptr]     : 3'd0;
    assign out_illegal = out_valid ? r_illegal[r_rd_ptr] : 1'b0;
    assign out_target  = out_valid ? r_target[r_rd_ptr]  : '0;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Testbench for imm_decode_pipe. Two instances share stimulus:
// dut_a is RV32 (XLEN=32, RV64I=0), dut_b is RV64 (XLEN=64, RV64I=1).
// Expected values come from arithmetic field extraction and a queue model.
module tb_imm_decode_pipe;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic        out_ready;
    logic [31:0] pc_a;
    logic [63:0] pc_b;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_imm, a_out_target;
    logic [2:0]  a_out_fmt;
    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [63:0] b_out_imm, b_out_target;
    logic [2:0]  b_out_fmt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [63:0] tgt;
    } ent_t;

    ent_t qa[$];
    ent_t qb[$];

    logic [6:0] ops [15] = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h33,
                             7'h13, 7'h1B, 7'h3B, 7'h0F, 7'h73, 7'h7F, 7'h12};

    imm_decode_pipe #(.XLEN(32), .DEPTH(DEPTH), .RV64I(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_inst(in_inst), .in_pc(pc_a),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_out_imm),
        .out_fmt(a_out_fmt), .out_target(a_out_target), .out_illegal(a_out_illegal)
    );

    imm_decode_pipe #(.XLEN(64), .DEPTH(DEPTH), .RV64I(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_inst(in_inst), .in_pc(pc_b),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_out_imm),
        .out_fmt(b_out_fmt), .out_target(b_out_target), .out_illegal(b_out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint sext(input longint v, input int bits);
        longint h;
        h = longint'(1) << (bits - 1);
        return (v >= h) ? v - (h << 1) : v;
    endfunction

    // Reference decoder working on numeric field values.
    function automatic ent_t ref_entry(input logic [31:0] inst, input logic [63:0] pc, input bit x64);
        longint unsigned u;
        longint          v;
        int              opc, f3;
        logic [63:0]     mask;
        ent_t            e;
        u = longint'(inst);
        opc = int'(u % 128);
        f3 = int'((u >> 12) % 8);
        mask = x64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        e.fmt = 3'd7; e.ill = 1'b1; v = 0;
        if (opc == 3 || opc == 103 || opc == 15 || opc == 115) begin
            e.fmt = 3'd1; v = sext(longint'(u >> 20), 12);
        end else if (opc == 19 || (opc == 27 && x64)) begin
            if (f3 == 1 || f3 == 5) begin
                e.fmt = 3'd6; v = longint'((u >> 20) % (x64 ? 64 : 32));
            end else begin
                e.fmt = 3'd1; v = sext(longint'(u >> 20), 12);
            end
        end else if (opc == 35) begin
            e.fmt = 3'd2; v = sext(longint'(((u >> 25) << 5) | ((u >> 7) % 32)), 12);
        end else if (opc == 99) begin
            e.fmt = 3'd3;
            v = sext(longint'(((u >> 31) << 12) | (((u >> 7) % 2) << 11) |
                              (((u >> 25) % 64) << 5) | (((u >> 8) % 16) << 1)), 13);
        end else if (opc == 55 || opc == 23) begin
            e.fmt = 3'd4; v = sext(longint'((u >> 12) << 12), 32);
        end else if (opc == 111) begin
            e.fmt = 3'd5;
            v = sext(longint'(((u >> 31) << 20) | (((u >> 12) % 256) << 12) |
                              (((u >> 20) % 2) << 11) | (((u >> 21) % 1024) << 1)), 21);
        end else if (opc == 51 || (opc == 59 && x64)) begin
            e.fmt = 3'd0; v = 0;
        end
        if (e.fmt != 3'd7) e.ill = 1'b0;
        e.imm = 64'(v) & mask;
        e.tgt = (pc + 64'(v)) & mask;
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 14)];
        return w;
    endfunction

    function automatic logic [69:0] obs_a();
        return {a_in_ready, a_out_valid, a_out_imm, a_out_fmt, a_out_illegal, a_out_target};
    endfunction

    function automatic logic [133:0] obs_b();
        return {b_in_ready, b_out_valid, b_out_imm, b_out_fmt, b_out_illegal, b_out_target};
    endfunction

    function automatic logic [69:0] exp_a();
        logic [69:0] e;
        e = '0;
        e[69] = (qa.size() != DEPTH);
        if (qa.size() > 0) begin
            e[68] = 1'b1; e[67:36] = qa[0].imm[31:0]; e[35:33] = qa[0].fmt;
            e[32] = qa[0].ill; e[31:0] = qa[0].tgt[31:0];
        end
        return e;
    endfunction

    function automatic logic [133:0] exp_b();
        logic [133:0] e;
        e = '0;
        e[133] = (qb.size() != DEPTH);
        if (qb.size() > 0) begin
            e[132] = 1'b1; e[131:68] = qb[0].imm; e[67:65] = qb[0].fmt;
            e[64] = qb[0].ill; e[63:0] = qb[0].tgt;
        end
        return e;
    endfunction

    // Applies one cycle of inputs at a falling edge, advances the model to
    // match the coming rising edge, and returns at the next falling edge.
    task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                                 input logic ordy, input logic fl, output bit acc);
        bit full;
        in_valid = v; in_inst = inst; pc_a = pc[31:0]; pc_b = pc; out_ready = ordy; flush = fl;
        acc = 1'b0;
        if (fl) begin
            qa.delete(); qb.delete();
        end else begin
            full = (qa.size() == DEPTH);
            if (qa.size() > 0 && ordy) begin
                void'(qa.pop_front()); void'(qb.pop_front());
            end
            if (v && !full) begin
                qa.push_back(ref_entry(inst, pc, 1'b0));
                qb.push_back(ref_entry(inst, pc, 1'b1));
                acc = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; out_ready = 1'b0;
        pc_a = '0; pc_b = '0;
        #3;
        checks++;
        if (obs_a() !== {1'b1, 69'd0}) begin
            errors++; $display("[TB] FAIL reset_a: got %h expected %h", obs_a(), {1'b1, 69'd0});
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_b() !== {1'b1, 133'd0}) begin
            errors++; $display("[TB] FAIL reset_b: got %h expected %h", obs_b(), {1'b1, 133'd0});
        end
    endtask

    task automatic test_decode_directed();
        logic [31:0] tinst [8] = '{32'hFFF00093, 32'h123450B7, 32'h0080006F, 32'h4030D093,
                                   32'hFE000EE3, 32'h00000000, 32'h03F09093, 32'h0000009B};
        logic [63:0] tpc   [8] = '{64'h0, 64'h0, 64'h100, 64'h0, 64'h10, 64'h0, 64'h0, 64'h0};
        logic [37:0] ta    [8] = '{{32'hFFFFFFFF, 3'd1, 1'b0, 2'b0}, {32'h12345000, 3'd4, 1'b0, 2'b0},
                                   {32'h00000008, 3'd5, 1'b0, 2'b0}, {32'h00000003, 3'd6, 1'b0, 2'b0},
                                   {32'hFFFFFFFC, 3'd3, 1'b0, 2'b0}, {32'h00000000, 3'd7, 1'b1, 2'b0},
                                   {32'h0000001F, 3'd6, 1'b0, 2'b0}, {32'h00000000, 3'd7, 1'b1, 2'b0}};
        logic [63:0] ttga  [8] = '{64'hFFFFFFFF, 64'h12345000, 64'h108, 64'h3, 64'hC, 64'h0, 64'h1F, 64'h0};
        logic [63:0] timb  [8] = '{64'hFFFFFFFF_FFFFFFFF, 64'h12345000, 64'h8, 64'h3,
                                   64'hFFFFFFFF_FFFFFFFC, 64'h0, 64'h3F, 64'h0};
        logic [63:0] ttgb  [8] = '{64'hFFFFFFFF_FFFFFFFF, 64'h12345000, 64'h108, 64'h3,
                                   64'hC, 64'h0, 64'h3F, 64'h0};
        logic [3:0]  tfib  [8] = '{{3'd1, 1'b0}, {3'd4, 1'b0}, {3'd5, 1'b0}, {3'd6, 1'b0},
                                   {3'd3, 1'b0}, {3'd7, 1'b1}, {3'd6, 1'b0}, {3'd1, 1'b0}};
        logic [68:0]  ea;
        logic [132:0] eb;
        bit acc;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (a_out_valid !== 1'b0) begin
                errors++; $display("[TB] FAIL pre_valid_%0d: got %b expected 0", i, a_out_valid);
            end
            applyStimulus(1'b1, tinst[i], tpc[i], 1'b1, 1'b0, acc);
            ea = {1'b1, ta[i][37:2], ttga[i][31:0]};
            eb = {1'b1, timb[i], tfib[i], ttgb[i]};
            checks++;
            if (obs_a()[68:0] !== ea) begin
                errors++; $display("[TB] FAIL dec_a_%0d: got %h expected %h", i, obs_a()[68:0], ea);
            end
            checks++;
            if (obs_b()[132:0] !== eb) begin
                errors++; $display("[TB] FAIL dec_b_%0d: got %h expected %h", i, obs_b()[132:0], eb);
            end
            applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);
            checks++;
            if (obs_a() !== {1'b1, 69'd0}) begin
                errors++; $display("[TB] FAIL empty_mask_%0d: got %h expected %h", i, obs_a(), {1'b1, 69'd0});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] items [4];
        logic [63:0] pcs   [4];
        int k, seen;
        bit acc;
        k = 0; seen = 0;
        for (int i = 0; i < 4; i++) begin
            items[i] = rand_inst(); pcs[i] = {$urandom, $urandom};
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (obs_a() !== exp_a()) begin
                errors++; $display("[TB] FAIL bp_fill_a: got %h expected %h", obs_a(), exp_a());
            end
            applyStimulus(1'b1, items[k], pcs[k], 1'b0, 1'b0, acc);
            if (acc) k++;
        end
        checks++;
        if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_full: got %b%b expected 00", a_in_ready, b_in_ready);
        end
        for (int c = 0; c < 20 && seen < 4; c++) begin
            checks++;
            if (obs_a() !== exp_a()) begin
                errors++; $display("[TB] FAIL bp_drain_a: got %h expected %h", obs_a(), exp_a());
            end
            checks++;
            if (obs_b() !== exp_b()) begin
                errors++; $display("[TB] FAIL bp_drain_b: got %h expected %h", obs_b(), exp_b());
            end
            if (a_out_valid === 1'b1) seen++;
            applyStimulus(k < 4, items[k % 4], pcs[k % 4], 1'b1, 1'b0, acc);
            if (acc) k++;
        end
        checks++;
        if (seen !== 4) begin
            errors++; $display("[TB] FAIL bp_count: got %0d expected 4", seen);
        end
    endtask

    task automatic test_flush();
        bit acc;
        applyStimulus(1'b1, rand_inst(), 64'h200, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, rand_inst(), 64'h204, 1'b0, 1'b0, acc);
        checks++;
        if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_pre: got %b%b expected 10", a_out_valid, a_in_ready);
        end
        applyStimulus(1'b1, 32'h00100093, 64'h208, 1'b1, 1'b1, acc);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs_a() !== {1'b1, 69'd0}) begin
                errors++; $display("[TB] FAIL flush_a: got %h expected %h", obs_a(), {1'b1, 69'd0});
            end
            checks++;
            if (obs_b() !== {1'b1, 133'd0}) begin
                errors++; $display("[TB] FAIL flush_b: got %h expected %h", obs_b(), {1'b1, 133'd0});
            end
            applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);
        end
    endtask

    task automatic test_reset_midstream();
        bit acc;
        applyStimulus(1'b1, rand_inst(), 64'h300, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, rand_inst(), 64'h304, 1'b0, 1'b0, acc);
        #2;
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (obs_a() !== {1'b1, 69'd0}) begin
            errors++; $display("[TB] FAIL rst_mid_a: got %h expected %h", obs_a(), {1'b1, 69'd0});
        end
        checks++;
        if (obs_b() !== {1'b1, 133'd0}) begin
            errors++; $display("[TB] FAIL rst_mid_b: got %h expected %h", obs_b(), {1'b1, 133'd0});
        end
        qa.delete(); qb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'h123450B7, 64'h40, 1'b1, 1'b0, acc);
        checks++;
        if (obs_a()[68:0] !== {1'b1, 32'h12345000, 3'd4, 1'b0, 32'h12345040}) begin
            errors++; $display("[TB] FAIL rst_after: got %h expected %h", obs_a()[68:0],
                               {1'b1, 32'h12345000, 3'd4, 1'b0, 32'h12345040});
        end
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);
    endtask

    task automatic test_random();
        bit acc;
        for (int c = 0; c < 400; c++) begin
            checks++;
            if (obs_a() !== exp_a()) begin
                errors++; $display("[TB] FAIL rand_a_%0d: got %h expected %h", c, obs_a(), exp_a());
            end
            checks++;
            if (obs_b() !== exp_b()) begin
                errors++; $display("[TB] FAIL rand_b_%0d: got %h expected %h", c, obs_b(), exp_b());
            end
            applyStimulus($urandom_range(0, 3) != 0, rand_inst(), {$urandom, $urandom},
                          $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, acc);
        end
    endtask

    initial begin
        test_reset();
        test_decode_directed();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
